// File: rtl/two24_dsp_sched.sv
// two24_dsp_sched: round-robin scheduler that time-shares one TWO24 SIMD DSP adder
// (two 24-bit lanes, AB op C) among NREQ requesters. It accepts one operand pair per cycle,
// drives the DSP from a registered issue stage, carries the requester ID alongside the DSP
// latency and returns each result tagged with that ID.
// Build option: define TWO24_DSP_SCHED_PRIO_EN for fixed priority (lowest index wins);
// burst lock is still honoured in that build.
module two24_dsp_sched #(
    parameter int NREQ  = 4,
    parameter int ABREG = 1,
    parameter int PREG  = 1,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NREQ-1:0]     req_valid_i,
    input  logic [NREQ-1:0]     req_lock_i,
    input  logic [NREQ*48-1:0]  req_ab_i,
    input  logic [NREQ*48-1:0]  req_c_i,
    output logic [NREQ-1:0]     req_ready_o,
    output logic [47:0]         dsp_ab_o,
    output logic [47:0]         dsp_c_o,
    input  logic [47:0]         dsp_p_i,
    input  logic [1:0]          dsp_carry_i,
    output logic                res_valid_o,
    output logic [IDW-1:0]      res_id_o,
    output logic [47:0]         res_p_o,
    output logic [1:0]          res_carry_o
);

    // One stage per DSP register plus the issue stage.
    localparam int DEPTH = ABREG + PREG + 1;

    typedef enum logic {ST_ARB, ST_LOCKED} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic           hs;
    logic [IDW-1:0] hs_id;
    int             start;
    int             idx;

    logic [47:0]    dsp_ab_q, dsp_c_q;
    logic [DEPTH-1:0] vld_q;
    logic [IDW-1:0] id_q [DEPTH];

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
        return IDW'((int'(i) + 1) % NREQ);
    endfunction

    // Grant selection and next arbitration state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        req_ready_o = '0;
        hs          = 1'b0;
        hs_id       = '0;
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_id_d   = lock_id_q;
        idx         = 0;
`ifdef TWO24_DSP_SCHED_PRIO_EN
        start       = 0;
`else
        // A lock whose owner has dropped valid hands the search to the next index this same cycle.
        start       = (state_q == ST_LOCKED) ? (int'(lock_id_q) + 1) % NREQ : int'(ptr_q);
`endif

        if (!rst_i) begin
            if (state_q == ST_LOCKED && req_valid_i[lock_id_q]) begin
                hs    = 1'b1;
                hs_id = lock_id_q;
            end else begin
                if (state_q == ST_LOCKED) begin
                    state_d = ST_ARB;
                    ptr_d   = wrap_inc(lock_id_q);
                end
                for (int k = 0; k < NREQ; k++) begin
                    idx = (start + k) % NREQ;
                    if (!hs && req_valid_i[idx]) begin
                        hs    = 1'b1;
                        hs_id = IDW'(idx);
                    end
                end
            end

            if (hs) begin
                req_ready_o[hs_id] = 1'b1;
                if (req_lock_i[hs_id]) begin
                    state_d   = ST_LOCKED;
                    lock_id_d = hs_id;
                end else begin
                    state_d   = ST_ARB;
                    ptr_d     = wrap_inc(hs_id);
                end
            end
        end
    end

    // Arbitration state, issue registers and the ID tracking pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_ARB;
            ptr_q     <= '0;
            lock_id_q <= '0;
            dsp_ab_q  <= '0;
            dsp_c_q   <= '0;
            vld_q     <= '0;
            // NOTE: the ID pipeline is cleared too so res_id_o reads 0 out of reset.
            for (int k = 0; k < DEPTH; k++) id_q[k] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the pre-edge value.
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_id_q <= lock_id_d;
            if (hs) begin
                dsp_ab_q <= req_ab_i[48*hs_id +: 48];
                dsp_c_q  <= req_c_i[48*hs_id +: 48];
            end
            vld_q[0] <= hs;
            id_q[0]  <= hs_id;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                id_q[k]  <= id_q[k-1];
            end
        end
    end

    assign dsp_ab_o    = dsp_ab_q;
    assign dsp_c_o     = dsp_c_q;
    assign res_valid_o = vld_q[DEPTH-1];
    assign res_id_o    = id_q[DEPTH-1];
    assign res_p_o     = dsp_p_i;
    assign res_carry_o = dsp_carry_i;

endmodule

// File: tb/tb_two24_dsp_sched.sv
// tb_two24_dsp_sched: randomized and directed bench for two24_dsp_sched with a registered-add
// DSP stand-in (ABREG=PREG=1) and a behavioural scheduling/result model.
module tb_two24_dsp_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    valid, lock;
    logic [NREQ*48-1:0] ab, c;
    logic [NREQ-1:0]    ready;
    logic [47:0]        dsp_ab, dsp_c, dsp_p;
    logic [1:0]         dsp_carry;
    logic               res_valid;
    logic [IDW-1:0]     res_id;
    logic [47:0]        res_p;
    logic [1:0]         res_carry;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    two24_dsp_sched #(.NREQ(NREQ), .ABREG(1), .PREG(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(valid), .req_lock_i(lock),
        .req_ab_i(ab), .req_c_i(c),
        .req_ready_o(ready),
        .dsp_ab_o(dsp_ab), .dsp_c_o(dsp_c),
        .dsp_p_i(dsp_p), .dsp_carry_i(dsp_carry),
        .res_valid_o(res_valid), .res_id_o(res_id),
        .res_p_o(res_p), .res_carry_o(res_carry)
    );

    // DSP stand-in: input register then P register, lane-wise add with carry out.
    logic [47:0] a_r, c_r;
    always @(posedge clk) begin
        a_r <= dsp_ab;
        c_r <= dsp_c;
        dsp_p     <= {lane_sum(a_r[47:24], c_r[47:24]), lane_sum(a_r[23:0], c_r[23:0])};
        dsp_carry <= {lane_cy(a_r[47:24], c_r[47:24]), lane_cy(a_r[23:0], c_r[23:0])};
    end

    function automatic logic [23:0] lane_sum(input logic [23:0] x, input logic [23:0] y);
        return x + y;
    endfunction

    function automatic logic lane_cy(input logic [23:0] x, input logic [23:0] y);
        logic [24:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[24];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    int           m_ptr = 0;
    bit           m_locked = 0;
    int           m_lid = 0;
    bit           slot_v  [8];
    int           slot_id [8];
    logic [47:0]  slot_p  [8];
    logic [1:0]   slot_cy [8];

    function automatic int pick(input logic [NREQ-1:0] v, input int from);
        for (int k = 0; k < NREQ; k++)
            if (v[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    // Compare DUT against the model every cycle, then advance the model by one cycle.
    always @(negedge clk) begin
        int s, g, from, d;
        logic [NREQ-1:0] exp_rdy;
        logic [47:0] op_ab, op_c;
        if (cyc > 0) begin
            s = cyc % 8;
            check("res_valid", 64'(res_valid), 64'(slot_v[s]));
            if (slot_v[s]) begin
                check("res_id", 64'(res_id), 64'(slot_id[s]));
                check("res_p", 64'(res_p), 64'(slot_p[s]));
                check("res_carry", 64'(res_carry), 64'(slot_cy[s]));
            end
            slot_v[s] = 1'b0;

            if (rst) g = -1;
            else if (m_locked && valid[m_lid]) g = m_lid;
            else begin
`ifdef TWO24_DSP_SCHED_PRIO_EN
                from = 0;
`else
                from = m_locked ? (m_lid + 1) % NREQ : m_ptr;
`endif
                g = pick(valid, from);
            end
            exp_rdy = (g < 0) ? '0 : NREQ'(1) << g;
            check("req_ready", 64'(ready), 64'(exp_rdy));

            if (rst) begin
                m_ptr = 0;
                m_locked = 0;
                for (int k = 0; k < 8; k++) slot_v[k] = 1'b0;
            end else begin
                if (m_locked && !valid[m_lid]) begin
                    m_locked = 0;
                    m_ptr = (m_lid + 1) % NREQ;
                end
                if (g >= 0) begin
                    if (lock[g]) begin
                        m_locked = 1;
                        m_lid = g;
                    end else begin
                        m_locked = 0;
                        m_ptr = (g + 1) % NREQ;
                    end
                    op_ab = ab[48*g +: 48];
                    op_c  = c[48*g +: 48];
                    d = (cyc + 3) % 8;
                    slot_v[d]  = 1'b1;
                    slot_id[d] = g;
                    slot_p[d]  = {lane_sum(op_ab[47:24], op_c[47:24]), lane_sum(op_ab[23:0], op_c[23:0])};
                    slot_cy[d] = {lane_cy(op_ab[47:24], op_c[47:24]), lane_cy(op_ab[23:0], op_c[23:0])};
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        valid = '0;
        lock = '0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            ab[48*i +: 48] = 48'({$urandom, $urandom});
            c[48*i +: 48]  = 48'({$urandom, $urandom});
        end
    endtask

    initial begin
        logic [NREQ-1:0] exp_g;
        logic [NREQ-1:0] lock_seq [6];
        rst = 1'b1; valid = '1; lock = '0; ab = '0; c = '0;

        // Reset held with every requester valid.
        repeat (3) begin
            next_cycle();
            sample();
            check("reset ready", 64'(ready), 64'(0));
            check("reset res_valid", 64'(res_valid), 64'(0));
            check("reset dsp_ab", 64'(dsp_ab), 64'(0));
        end

        // Single op from requester 2.
        next_cycle();
        rst = 1'b0;
        valid = 4'b0100;
        ab[96 +: 48] = {24'd5, 24'd7};
        c[96 +: 48]  = {24'd1, 24'd2};
        sample();
        check("single ready", 64'(ready), 64'(4'b0100));
        next_cycle();
        valid = '0;
        sample();
        check("single early0", 64'(res_valid), 64'(0));
        next_cycle();
        sample();
        check("single early1", 64'(res_valid), 64'(0));
        next_cycle();
        sample();
        check("single res_valid", 64'(res_valid), 64'(1));
        check("single res_id", 64'(res_id), 64'(2));
        check("single res_p", 64'(res_p), 64'({24'd6, 24'd9}));
        next_cycle();

        // All four valid continuously.
        reset_pulse();
        valid = '1;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            sample();
`ifdef TWO24_DSP_SCHED_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = NREQ'(1) << (k % NREQ);
`endif
            check($sformatf("all-valid grant %0d", k), 64'(ready), 64'(exp_g));
            next_cycle();
        end
        valid = '0;
        repeat (4) next_cycle();

`ifndef TWO24_DSP_SCHED_PRIO_EN
        // Burst lock by requester 1 while 0 and 3 wait; then release by valid drop.
        reset_pulse();
        valid = 4'b0001;
        sample();
        check("lock setup grant", 64'(ready), 64'(4'b0001));
        next_cycle();
        lock_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
        for (int k = 0; k < 6; k++) begin
            valid = (k < 4) ? 4'b1011 : 4'b1001;
            lock  = (k < 3) ? 4'b0010 : 4'b0000;
            rand_ops();
            sample();
            check($sformatf("lock grant %0d", k), 64'(ready), 64'(lock_seq[k]));
            next_cycle();
        end
        valid = 4'b0100; lock = 4'b0100;
        sample();
        check("drop lock enter", 64'(ready), 64'(4'b0100));
        next_cycle();
        valid = 4'b1011; lock = '0;
        sample();
        check("drop lock handoff", 64'(ready), 64'(4'b1000));
        next_cycle();
        sample();
        check("drop lock next", 64'(ready), 64'(4'b0001));
        next_cycle();
        valid = '0;
        repeat (4) next_cycle();
`endif

        // Lane 0 overflow, lane 1 independent.
        valid = 4'b0001;
        ab[0 +: 48] = {24'd10, 24'hFFFFFF};
        c[0 +: 48]  = {24'd20, 24'd1};
        sample();
        check("carry ready", 64'(ready), 64'(4'b0001));
        next_cycle();
        valid = '0;
        repeat (2) begin sample(); next_cycle(); end
        sample();
        check("carry res_valid", 64'(res_valid), 64'(1));
        check("carry lane0", 64'(res_p[23:0]), 64'(0));
        check("carry lane1", 64'(res_p[47:24]), 64'(30));
        check("carry bits", 64'(res_carry), 64'(2'b01));
        next_cycle();

        // Reset while two ops are in flight.
        reset_pulse();
        valid = 4'b0011;
        rand_ops();
        sample();
        check("flight grant0", 64'(ready), 64'(4'b0001));
        next_cycle();
        sample();
        check("flight grant1", 64'(ready), 64'(4'b0010));
        next_cycle();
        rst = 1'b1; valid = '0;
        for (int k = 0; k < 5; k++) begin
            sample();
            check($sformatf("flight dropped %0d", k), 64'(res_valid), 64'(0));
            next_cycle();
            rst = 1'b0;
        end
        valid = '1;
        sample();
        check("flight ptr reset", 64'(ready), 64'(4'b0001));
        next_cycle();
        valid = '0;

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            rst   = ($urandom_range(0, 99) == 0);
            valid = NREQ'($urandom) | NREQ'($urandom);
            lock  = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
            rand_ops();
            next_cycle();
        end
        rst = 1'b0; valid = '0; lock = '0;
        repeat (6) next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
